print_serializer: RTL
=====================

// Module: print_serializer
// PURPOSE
//  Parametrised TX-path serializer for the serial debug unit. Accepts one word of
//  1..NBYTES bytes and emits it one byte per valid/ready transfer to the UART TX.
//  Byte order is selectable, and an optional ASCII-hex mode emits two characters per byte.
//  Ends each request with a one-cycle ack_tx pulse.
// PARAMETERS
//  NBYTES  4  bytes per input word, >=2; dout_tx width = 8*NBYTES
//  LW      $clog2(NBYTES)  derived localparam, width of len_tx
// PORTS
//  clk_tx    in   1          single clock, all logic on posedge
//  rst_n     in   1          asynchronous, active-low reset
//  req_tx    in   1          request; sampled only in IDLE
//  dout_tx   in   8*NBYTES   word to print; byte k = dout_tx[8k+7:8k]
//  len_tx    in   LW         bytes to send minus 1 (0 = 1 byte, NBYTES-1 = full word)
//  order_tx  in   1          0 = byte 0 first (LE); 1 = byte len_tx first, down to byte 0 (BE)
//  hex_tx    in   1          0 = raw bytes; 1 = two ASCII hex chars per byte, high nibble first
//  rdy_tx    in   1          downstream ready
//  vld_tx    out  1          d_tx valid
//  d_tx      out  8          output character/byte
//  ack_tx    out  1          one-cycle pulse: request fully transferred
//  busy_tx   out  1          high from accept until the ack cycle inclusive
// BEHAVIOUR
//  - Reset (async on rst_n low): state=IDLE, vld_tx=0, d_tx=8'h00, ack_tx=0, busy_tx=0, counters 0.
//  - FSM: IDLE -> SEND on posedge with req_tx=1. SEND -> DONE on the last vld&&rdy transfer.
//    DONE -> IDLE unconditionally after 1 cycle.
//  - Accept edge: latch dout_tx, len_tx, order_tx and hex_tx. Inputs may change afterwards.
//    The next cycle has vld_tx=1 with the first character on d_tx.
//  - Transfer = posedge with vld_tx&&rdy_tx. On that edge, d_tx advances to the next character.
//    vld_tx stays high with no bubbles between characters of one request.
//  - vld_tx&&!rdy_tx: d_tx and vld_tx hold stable. No character is dropped or duplicated.
//  - Character count = len_tx+1 (raw mode) or 2*(len_tx+1) (hex mode).
//  - The byte index counter runs 0..len_tx. For BE, the byte sent is len_tx-index.
//    In hex mode a nibble-phase bit toggles per transfer; the index advances after the low nibble.
//  - Hex encoding: nibble 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10). Uppercase only.
//  - Last transfer edge: vld_tx->0, ack_tx->1 (DONE). The next edge sets ack_tx->0 and state IDLE.
//    A new request is accepted no earlier than the edge after ack_tx falls.
//  - req_tx is ignored in SEND/DONE (no queuing). If req_tx is held high, exactly one request
//    is accepted per ack.
//  - Minimum latency: len_tx=0, raw, rdy=1 gives accept edge, 1 transfer edge, ack the cycle after.
//  - Reset mid-SEND: abort immediately, no ack. The next request starts at character 0.
//  - d_tx retains its last value while vld_tx=0. Consumers must not sample it then.
// STRUCTURE
//  - Package print_pkg: FSM state enum {IDLE,SEND,DONE}, ASCII_0=8'h30, ASCII_A=8'h41,
//    function hex_char(nibble)->8-bit ASCII.
//  - Single module. The byte/nibble select mux is combinational inside it.
//    No sub-module is needed. All outputs are registered.
// TESTING
//  1 NBYTES=4, dout=32'h44332211, len=3, LE, raw, rdy=1 -> d_tx 11,22,33,44 on 4 consecutive
//    cycles; ack_tx high for exactly 1 cycle after 44.
//  2 Same word, order_tx=1 -> d_tx 44,33,22,11. Then len=1, BE -> 22,11.
//  3 len=0, hex=1, dout[7:0]=8'hA7 -> d_tx 8'h41, 8'h37, then ack. len=1, dout[15:0]=16'h0F3C,
//    LE, hex -> 33,43,30,46.
//  4 rdy_tx toggling 1010..., plus a 5-cycle stall, during test 1 -> d_tx stable while stalled;
//    scoreboard sees exactly 11,22,33,44.
//  5 req_tx held high for 20 cycles, len=1 raw -> two bytes then ack, repeated. req pulses during
//    SEND/DONE are ignored. Changing dout_tx after accept does not alter the output.
//  6 rst_n low after 2nd transfer of test 1 -> vld_tx=0 asynchronously, no ack. The next request
//    emits 11 first.

Source files
------------

// File: rtl/print_pkg.sv
// Shared types and ASCII helpers for the print serializer.
package print_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;

  // Map one nibble to its uppercase ASCII hex character.
  function automatic logic [7:0] hex_char(input logic [3:0] nibble);
    logic [7:0] n8;
    n8 = {4'h0, nibble};
    if (nibble < 4'd10) return ASCII_0 + n8;
    return ASCII_A + n8 - 8'd10;
  endfunction

endpackage

// File: rtl/print_serializer.sv
// TX-path serializer: emits a 1..NBYTES byte word one character per
// valid/ready transfer, LE or BE byte order, raw or ASCII-hex encoding.
module print_serializer
  import print_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int LW     = $clog2(NBYTES)
) (
  input  logic                  clk_tx,
  input  logic                  rst_n,
  input  logic                  req_tx,
  input  logic [8*NBYTES-1:0]   dout_tx,
  input  logic [LW-1:0]         len_tx,
  input  logic                  order_tx,
  input  logic                  hex_tx,
  input  logic                  rdy_tx,
  output logic                  vld_tx,
  output logic [7:0]            d_tx,
  output logic                  ack_tx,
  output logic                  busy_tx
);

  state_t              state;
  logic [8*NBYTES-1:0] word_q;
  logic [LW-1:0]       len_q;
  logic                order_q;
  logic                hex_q;
  logic [LW-1:0]       idx;
  logic                phase;

  logic [LW-1:0]       next_idx;
  logic                next_phase;
  logic                last;
  logic                accept;
  logic [7:0]          first_char;
  logic [7:0]          next_char;

  // Character for a given byte index / nibble phase of a word.
  function automatic logic [7:0] pick_char(
    input logic [8*NBYTES-1:0] word,
    input logic [LW-1:0]       len,
    input logic                order,
    input logic                hex,
    input logic [LW-1:0]       index,
    input logic                nib_lo
  );
    logic [LW-1:0] sel;
    logic [7:0]    byte_val;
    sel      = order ? (len - index) : index;
    byte_val = word[{sel, 3'b000} +: 8];
    if (!hex) return byte_val;
    return nib_lo ? hex_char(byte_val[3:0]) : hex_char(byte_val[7:4]);
  endfunction

  assign accept = (state == IDLE) && req_tx;

  // Next character position and the byte/nibble select mux.
  always_comb begin
    next_idx   = idx;
    next_phase = 1'b0;
    if (hex_q && !phase) begin
      next_phase = 1'b1;
    end else begin
      next_idx = idx + 1'b1;
    end
    last       = (idx == len_q) && (!hex_q || phase);
    first_char = pick_char(dout_tx, len_tx, order_tx, hex_tx, '0, 1'b0);
    next_char  = pick_char(word_q, len_q, order_q, hex_q, next_idx, next_phase);
  end

  // Request fields are captured on the accept edge so inputs may change afterwards.
  always_ff @(posedge clk_tx) begin
    if (accept) begin
      word_q  <= dout_tx;
      len_q   <= len_tx;
      order_q <= order_tx;
      hex_q   <= hex_tx;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vld_tx  <= 1'b0;
      d_tx    <= 8'h00;
      ack_tx  <= 1'b0;
      busy_tx <= 1'b0;
      idx     <= '0;
      phase   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_tx <= 1'b0;
          if (req_tx) begin
            state   <= SEND;
            vld_tx  <= 1'b1;
            d_tx    <= first_char;
            busy_tx <= 1'b1;
            idx     <= '0;
            phase   <= 1'b0;
          end
        end
        SEND: begin
          if (vld_tx && rdy_tx) begin
            if (last) begin
              vld_tx <= 1'b0;
              ack_tx <= 1'b1;
              state  <= DONE;
            end else begin
              idx   <= next_idx;
              phase <= next_phase;
              d_tx  <= next_char;
            end
          end
        end
        DONE: begin
          ack_tx  <= 1'b0;
          busy_tx <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          vld_tx  <= 1'b0;
          ack_tx  <= 1'b0;
          busy_tx <= 1'b0;
        end
      endcase
    end
  end

endmodule
